// File: rtl/path_pkg.sv
// Shared definitions for the two-master memory path: scheduler states and master IDs.
package path_pkg;

  typedef enum logic [1:0] {
    OWN1 = 2'd0,
    OWN2 = 2'd1,
    HOLD = 2'd2
  } path_sched_state_t;

  // Master IDs match the ID bit carried along the path.
  localparam logic PATH_M1 = 1'b0;
  localparam logic PATH_M2 = 1'b1;

endpackage

// File: rtl/path_occ_cnt.sv
// Path FIFO occupancy tracker: saturating count, full/empty flags, sticky overflow/underflow.
module path_occ_cnt #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid1,
  input  logic          valid2,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic push;
  assign push = valid1 | valid2;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_nxt = count;
    if (push && !pop && count != FULL_CNT)
      count_nxt = count + 1'b1;
    else if (pop && !push && count != '0)
      count_nxt = count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
      // A double push is a protocol error even though only one beat is counted.
      if ((valid1 && valid2) || (push && !pop && count == FULL_CNT))
        overflow <= 1'b1;
      if (pop && !push && count == '0)
        underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/path_ingress_sched.sv
// Ingress scheduler: round-robin push ownership of the shared path FIFO with fill lookahead.
// Optional PATH_SCHED_BURST_EN lets an owner keep the slot for up to MAX_BURST beats.
module path_ingress_sched
  import path_pkg::*;
#(
  parameter  int DEPTH     = 4,
  parameter  int MAX_BURST = 4,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          want1_i,
  input  logic          want2_i,
  input  logic          valid1_i,
  input  logic          valid2_i,
  input  logic          pop_i,
  output logic          stop1_o,
  output logic          stop2_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  if (DEPTH < 2 || MAX_BURST < 1) begin : g_param_check
    $error("path_ingress_sched: DEPTH must be >= 2 and MAX_BURST >= 1");
  end

  path_sched_state_t state, state_nxt;
  logic              last_served, last_served_nxt;
  logic [CW-1:0]     count_nxt;
  logic              beat_acc;
  logic              yield;
  logic              pref;
  logic              pref_wants, other_wants;

  path_occ_cnt #(.DEPTH(DEPTH)) u_occ (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid1    (valid1_i),
    .valid2    (valid2_i),
    .pop       (pop_i),
    .count     (count_o),
    .count_nxt (count_nxt),
    .empty     (empty_o),
    .full      (full_o),
    .overflow  (overflow_o),
    .underflow (underflow_o)
  );

  assign beat_acc = (state == OWN1 && valid1_i) || (state == OWN2 && valid2_i);

`ifdef PATH_SCHED_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic [BW-1:0] burst_cnt, burst_after;

  always_comb begin
    burst_after = burst_cnt;
    if (beat_acc && burst_cnt != BURST_MAX)
      burst_after = burst_cnt + 1'b1;
  end

  // Owner yields on a beat only once its burst allowance is used up.
  assign yield = beat_acc && (burst_after == BURST_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      burst_cnt <= '0;
    else if (state_nxt != state || state_nxt == HOLD)
      burst_cnt <= '0;
    else
      burst_cnt <= burst_after;
  end
`else
  assign yield = beat_acc;
`endif

  // Round-robin preference: the master that was not served last.
  assign pref        = ~last_served_nxt;
  assign pref_wants  = (pref == PATH_M1) ? want1_i : want2_i;
  assign other_wants = (pref == PATH_M1) ? want2_i : want1_i;

  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    if (valid1_i)
      last_served_nxt = PATH_M1;
    else if (valid2_i)
      last_served_nxt = PATH_M2;

    if (count_nxt == CW'(DEPTH)) begin
      state_nxt = HOLD;
    end else begin
      unique case (state)
        OWN1: if (want2_i && (yield || !want1_i)) state_nxt = OWN2;
        OWN2: if (want1_i && (yield || !want2_i)) state_nxt = OWN1;
        HOLD: begin
          if (pref_wants || !other_wants)
            state_nxt = (pref == PATH_M1) ? OWN1 : OWN2;
          else
            state_nxt = (pref == PATH_M1) ? OWN2 : OWN1;
        end
        default: state_nxt = OWN1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OWN1;
      last_served <= PATH_M2;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
    end
  end

  assign stop1_o = (state != OWN1);
  assign stop2_o = (state != OWN2);

endmodule

// File: tb/tb_path_ingress_sched.sv
// Directed bench for path_ingress_sched in the default build (DEPTH=4, burst mode off).
module tb_path_ingress_sched;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          want1, want2, valid1, valid2, pop;
  logic          stop1, stop2;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  path_ingress_sched #(.DEPTH(DEPTH), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .want1_i     (want1),
    .want2_i     (want2),
    .valid1_i    (valid1),
    .valid2_i    (valid2),
    .pop_i       (pop),
    .stop1_o     (stop1),
    .stop2_o     (stop2),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample outputs 1 time unit after the rising edge.
  task automatic cycle(input logic w1, input logic w2, input logic v1, input logic v2,
                       input logic p);
    want1 = w1; want2 = w2; valid1 = v1; valid2 = v2; pop = p;
    @(posedge clk);
    #1;
    valid1 = 1'b0; valid2 = 1'b0; pop = 1'b0;
  endtask

  // Expected {stop1, stop2} encodings.
  localparam logic [1:0] S_OWN1 = 2'b01;
  localparam logic [1:0] S_OWN2 = 2'b10;
  localparam logic [1:0] S_HOLD = 2'b11;

  initial begin
    rst_n = 1'b0;
    want1 = 1'b0; want2 = 1'b0; valid1 = 1'b0; valid2 = 1'b0; pop = 1'b0;
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset: OWN1, empty, for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("idle_stops_%0d", i), {30'd0, stop1, stop2}, S_OWN1);
      check($sformatf("idle_count_%0d", i), count, 0);
      check($sformatf("idle_empty_%0d", i), empty, 1);
    end

    // Both want, push when unstopped: strict alternation M1,M2,M1,M2 then HOLD.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("fill1_stops", {30'd0, stop1, stop2}, S_OWN2);
    check("fill1_count", count, 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fill2_stops", {30'd0, stop1, stop2}, S_OWN1);
    check("fill2_count", count, 2);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("fill3_stops", {30'd0, stop1, stop2}, S_OWN2);
    check("fill3_count", count, 3);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fill4_stops", {30'd0, stop1, stop2}, S_HOLD);
    check("fill4_count", count, 4);
    check("fill4_full", full, 1);
    check("fill4_ovf", overflow, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_stops", {30'd0, stop1, stop2}, S_HOLD);
    check("hold_full", full, 1);

    // One pop from full: M1 (not served last) gets the slot.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("pop_count", count, 3);
    check("pop_full", full, 0);
    check("pop_stops", {30'd0, stop1, stop2}, S_OWN1);

    // Drain with no wants: owner stays unstopped.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("drain_stops", {30'd0, stop1, stop2}, S_OWN1);
    check("drain_unf", underflow, 0);

    // Bypass: push and pop together while empty.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("bypass_count", count, 0);
    check("bypass_unf", underflow, 0);
    check("bypass_stops", {30'd0, stop1, stop2}, S_OWN1);

    // M1 drops want while M2 wants: handover next cycle.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("handover_stops", {30'd0, stop1, stop2}, S_OWN2);

    // Pop alone while empty: sticky underflow.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("unf_set", underflow, 1);
    check("unf_count", count, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("unf_sticky", underflow, 1);
    check("unf_no_ovf", overflow, 0);

    // Double push is a protocol error counted as one beat.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("dbl_ovf", overflow, 1);
    check("dbl_count", count, 1);
    check("dbl_stops", {30'd0, stop1, stop2}, S_OWN1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pre_rst_count", count, 3);
    check("pre_rst_stops", {30'd0, stop1, stop2}, S_OWN1);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stops", {30'd0, stop1, stop2}, S_OWN1);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_ovf", overflow, 0);
    check("arst_unf", underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
